// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK register/counter.
package jk_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'b000,
    JK    = 3'b001,
    UP    = 3'b010,
    DOWN  = 3'b011,
    LOAD  = 3'b100,
    CLEAR = 3'b101
  } jk_mode_e;

  // Unassigned codes; both behave as HOLD and never raise wrap.
  localparam logic [2:0] MODE_RSVD0 = 3'b110;
  localparam logic [2:0] MODE_RSVD1 = 3'b111;

endpackage

// File: rtl/jk_reg_ctr_if.sv
// Control/data bundle for jk_reg_ctr.
interface jk_reg_ctr_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_b;
  logic             wrap;

  modport master (output en, mode, j, k, d, input q, q_b, wrap);
  modport slave  (input en, mode, j, k, d, output q, q_b, wrap);
endinterface

// File: rtl/jk_cell.sv
// Single JK storage bit with its own reset value.
module jk_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK update: 00 hold, 01 clear, 10 set, 11 toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_BIT;
    else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_reg_ctr.sv
// WIDTH-bit JK register/counter; every mode is expressed as per-bit J/K.
module jk_reg_ctr
  import jk_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SATURATE  = 0
) (
  input  logic         clk,
  input  logic         rst,
  jk_reg_ctr_if.slave  bus
);

  localparam bit SAT = (SATURATE != 0);

  logic [WIDTH-1:0] q_int;
  logic [WIDTH-1:0] j_eff, k_eff;
  logic [WIDTH-1:0] tog_up, tog_dn;
  logic             all_ones, all_zero;
  logic             wrap_nxt, wrap_q;

  assign all_ones = &q_int;
  assign all_zero = ~|q_int;

  // Ripple toggle conditions: up toggles above a run of 1s, down above a run of 0s.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_tog
      if (i == 0) begin : g_lsb
        assign tog_up[i] = 1'b1;
        assign tog_dn[i] = 1'b1;
      end else begin : g_upper
        assign tog_up[i] = &q_int[i-1:0];
        assign tog_dn[i] = ~|q_int[i-1:0];
      end
    end
  endgenerate

  // Map the selected mode onto per-bit J/K and decide whether this edge wraps.
  always_comb begin
    j_eff    = '0;
    k_eff    = '0;
    wrap_nxt = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        JK: begin
          j_eff = bus.j;
          k_eff = bus.k;
        end
        UP: begin
          if (!(SAT && all_ones)) begin
            j_eff = tog_up;
            k_eff = tog_up;
          end
          wrap_nxt = !SAT && all_ones;
        end
        DOWN: begin
          if (!(SAT && all_zero)) begin
            j_eff = tog_dn;
            k_eff = tog_dn;
          end
          wrap_nxt = !SAT && all_zero;
        end
        LOAD: begin
          j_eff = bus.d;
          k_eff = ~bus.d;
        end
        CLEAR: begin
          k_eff = '1;
        end
        default: ;
      endcase
    end
  end

  // Storage bits.
  generate
    for (i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell #(.RST_BIT(RESET_VAL[i])) u_cell (
        .clk (clk),
        .rst (rst),
        .j   (j_eff[i]),
        .k   (k_eff[i]),
        .q   (q_int[i])
      );
    end
  endgenerate

  // Wrap pulse lines up with the cycle that shows the wrapped value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_nxt;
  end

  assign bus.q    = q_int;
  assign bus.q_b  = ~q_int;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_jk_reg_ctr.sv
// Bench: wrapping and saturating instances driven in lockstep against a reference model.
module tb_jk_reg_ctr;

  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  jk_reg_ctr_if #(.WIDTH(8)) bus0 ();
  jk_reg_ctr_if #(.WIDTH(8)) bus1 ();

  jk_reg_ctr #(.WIDTH(8), .RESET_VAL(8'hA5), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .bus(bus0.slave));
  jk_reg_ctr #(.WIDTH(8), .RESET_VAL(8'hA5), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .bus(bus1.slave));

  logic [7:0] mq0, mq1;
  logic       mw0, mw1;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] j, k, d;
    logic [7:0] exp_q;
    logic       exp_w;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level behaviour: arithmetic on the whole value, not bit toggles.
  function automatic logic [8:0] ref_step(input logic [7:0] q, input bit sat, input logic en,
                                          input logic [2:0] mode, input logic [7:0] j,
                                          input logic [7:0] k, input logic [7:0] d);
    int v;
    if (!en) return {1'b0, q};
    case (mode)
      3'd1: return {1'b0, (q & ~j & ~k) | (j & ~k) | (~q & j & k)};
      3'd2: begin
        if (q == 8'hFF) return sat ? {1'b0, q} : {1'b1, 8'h00};
        v = (int'(q) + 1) % 256;
        return {1'b0, v[7:0]};
      end
      3'd3: begin
        if (q == 8'h00) return sat ? {1'b0, q} : {1'b1, 8'hFF};
        v = (int'(q) + 255) % 256;
        return {1'b0, v[7:0]};
      end
      3'd4: return {1'b0, d};
      3'd5: return 9'h000;
      default: return {1'b0, q};
    endcase
  endfunction

  task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] jj,
                       input logic [7:0] kk, input logic [7:0] dd);
    bus0.en = e; bus0.mode = m; bus0.j = jj; bus0.k = kk; bus0.d = dd;
    bus1.en = e; bus1.mode = m; bus1.j = jj; bus1.k = kk; bus1.d = dd;
  endtask

  task automatic check_model();
    chk("wrap_q",    bus0.q,           mq0);
    chk("wrap_q_b",  bus0.q_b,         ~mq0);
    chk("wrap_w",    {7'd0, bus0.wrap}, {7'd0, mw0});
    chk("sat_q",     bus1.q,           mq1);
    chk("sat_q_b",   bus1.q_b,         ~mq1);
    chk("sat_w",     {7'd0, bus1.wrap}, {7'd0, mw1});
  endtask

  // One clock: drive, advance model at the edge, sample 1 time unit later.
  task automatic do_cycle(input logic e, input logic [2:0] m, input logic [7:0] jj,
                          input logic [7:0] kk, input logic [7:0] dd);
    drive(e, m, jj, kk, dd);
    @(posedge clk);
    {mw0, mq0} = ref_step(mq0, 1'b0, e, m, jj, kk, dd);
    {mw1, mq1} = ref_step(mq1, 1'b1, e, m, jj, kk, dd);
    #1;
    check_model();
  endtask

  vec_t tbl[$];

  initial begin
    tbl = '{
      '{1'b1, 3'b100, 8'h00, 8'h00, 8'h0F, 8'h0F, 1'b0},
      '{1'b1, 3'b001, 8'hF0, 8'h3C, 8'h00, 8'hF3, 1'b0},
      '{1'b1, 3'b100, 8'h00, 8'h00, 8'hFE, 8'hFE, 1'b0},
      '{1'b1, 3'b010, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0},
      '{1'b1, 3'b010, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1},
      '{1'b1, 3'b011, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1},
      '{1'b0, 3'b010, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b0},
      '{1'b1, 3'b110, 8'hFF, 8'hFF, 8'h12, 8'hFF, 1'b0},
      '{1'b1, 3'b111, 8'hFF, 8'hFF, 8'h12, 8'hFF, 1'b0},
      '{1'b1, 3'b101, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0},
      '{1'b1, 3'b011, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1},
      '{1'b1, 3'b010, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1},
      '{1'b1, 3'b001, 8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b0},
      '{1'b1, 3'b001, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0}
    };

    // Reset state while rst is held.
    rst = 1'b1;
    drive(1'b0, 3'b000, 8'h00, 8'h00, 8'h00);
    mq0 = 8'hA5; mq1 = 8'hA5; mw0 = 1'b0; mw1 = 1'b0;
    #2;
    chk("rst_q",   bus0.q,   8'hA5);
    chk("rst_q_b", bus0.q_b, 8'h5A);
    chk("rst_w",   {7'd0, bus0.wrap}, 8'h00);
    chk("rst_sat_q", bus1.q, 8'hA5);
    #1 rst = 1'b0;

    // Directed table on the wrapping instance; saturating one follows the model.
    for (int n = 0; n < tbl.size(); n++) begin
      do_cycle(tbl[n].en, tbl[n].mode, tbl[n].j, tbl[n].k, tbl[n].d);
      chk($sformatf("tbl%0d_q", n), bus0.q, tbl[n].exp_q);
      chk($sformatf("tbl%0d_w", n), {7'd0, bus0.wrap}, {7'd0, tbl[n].exp_w});
    end

    // Saturation at both ends.
    do_cycle(1'b1, 3'b100, 8'h00, 8'h00, 8'hFF);
    for (int n = 0; n < 3; n++) begin
      do_cycle(1'b1, 3'b010, 8'h00, 8'h00, 8'h00);
      chk("sat_up_q", bus1.q, 8'hFF);
      chk("sat_up_w", {7'd0, bus1.wrap}, 8'h00);
    end
    do_cycle(1'b1, 3'b100, 8'h00, 8'h00, 8'h00);
    do_cycle(1'b1, 3'b011, 8'h00, 8'h00, 8'h00);
    chk("sat_dn_q", bus1.q, 8'h00);
    chk("sat_dn_w", {7'd0, bus1.wrap}, 8'h00);
    chk("wrap_dn_w", {7'd0, bus0.wrap}, 8'h01);

    // Reset during the wrap pulse, then the count resumes from the reset value.
    do_cycle(1'b1, 3'b100, 8'h00, 8'h00, 8'hFF);
    do_cycle(1'b1, 3'b010, 8'h00, 8'h00, 8'h00);
    chk("pre_rst_w", {7'd0, bus0.wrap}, 8'h01);
    #2 rst = 1'b1;
    mq0 = 8'hA5; mq1 = 8'hA5; mw0 = 1'b0; mw1 = 1'b0;
    #1;
    chk("midrst_q",   bus0.q,   8'hA5);
    chk("midrst_q_b", bus0.q_b, 8'h5A);
    chk("midrst_w",   {7'd0, bus0.wrap}, 8'h00);
    #1 rst = 1'b0;
    do_cycle(1'b1, 3'b010, 8'h00, 8'h00, 8'h00);
    chk("resume_q", bus0.q, 8'hA6);

    // Randomized traffic, biased toward counting and the end values.
    for (int n = 0; n < 400; n++) begin
      logic       e;
      logic [2:0] m;
      logic [7:0] dd;
      e  = ($urandom_range(0, 7) != 0);
      m  = 3'($urandom_range(0, 7));
      dd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) dd = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      if (m >= 3'd6 && $urandom_range(0, 1) != 0) m = 3'($urandom_range(2, 3));
      do_cycle(e, m, 8'($urandom), 8'($urandom), dd);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
